// File: rtl/seq_gen_arb_pkg.sv
// rtl/seq_gen_arb_pkg.sv - shared types and default parameters for seq_gen_arbiter
package seq_gen_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_LEN_W   = 8;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_STREAM = 1'b1
   } arb_state_t;

endpackage

// File: rtl/seq_gen_arbiter_rr_picker.sv
// rtl/seq_gen_arbiter_rr_picker.sv - combinational round-robin selector (module rr_picker)
// Picks the first eligible index at or after ptr_i, wrapping modulo N.
module rr_picker #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     eligible_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     winner_o,
   output logic             any_o
);

   always_comb begin
      logic             found;
      logic [PTR_W-1:0] idx;
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         idx = PTR_W'((int'(ptr_i) + i) % N);
         if (!found && eligible_i[idx]) begin
            winner_o[idx] = 1'b1;
            found         = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/seq_gen_arbiter.sv
// rtl/seq_gen_arbiter.sv - round-robin burst arbiter sharing one seq_generator
// Optional SEQ_GEN_ARB_ABORT_EN adds abort_i_w to cut a burst short.
module seq_gen_arbiter
   import seq_gen_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LEN_W   = DEF_LEN_W
) (
   input  logic                     clk_w,
   input  logic                     reset_n_w,
   input  logic [NUM_REQ-1:0]       req_i_w,
   input  logic [NUM_REQ*LEN_W-1:0] len_i_w,
   output logic [NUM_REQ-1:0]       gnt_o_w,
   output logic                     gen_rst_o_w,
   output logic                     gen_en_o_w,
   input  logic [DATA_W-1:0]        gen_seq_i_w,
   output logic [DATA_W-1:0]        data_o_w,
   output logic                     valid_o_w,
   input  logic                     ready_i_w,
`ifdef SEQ_GEN_ARB_ABORT_EN
   input  logic                     abort_i_w,
`endif
   output logic                     last_o_w,
   output logic                     done_o_w
);

   localparam int PTR_W = $clog2(NUM_REQ);

   arb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               done_q, done_d;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] winner;
   logic               any_elig;
   logic [LEN_W-1:0]   win_len;
   logic [PTR_W-1:0]   gnt_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic               hs;
   logic               last_beat;
   logic               abort;

`ifdef SEQ_GEN_ARB_ABORT_EN
   assign abort = abort_i_w;
`else
   assign abort = 1'b0;
`endif

   // Zero-length requests are filtered out here so they can never win.
   always_comb begin
      eligible = '0;
      win_len  = '0;
      gnt_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         eligible[k] = req_i_w[k] && (len_i_w[k*LEN_W +: LEN_W] != '0);
         if (winner[k]) win_len = win_len | len_i_w[k*LEN_W +: LEN_W];
         if (gnt_q[k])  gnt_idx = PTR_W'(k);
      end
   end

   rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_picker (
      .eligible_i (eligible),
      .ptr_i      (rr_ptr_q),
      .winner_o   (winner),
      .any_o      (any_elig)
   );

   assign next_ptr  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
   assign hs        = (state_q == ARB_STREAM) && ready_i_w;
   assign last_beat = (beat_q == len_q - LEN_W'(1));

   always_ff @(posedge clk_w or negedge reset_n_w) begin
      if (!reset_n_w) begin
         state_q  <= ARB_IDLE;
         gnt_q    <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         rr_ptr_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         rr_ptr_q <= rr_ptr_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      len_d    = len_q;
      beat_d   = beat_q;
      rr_ptr_d = rr_ptr_q;
      done_d   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (any_elig) begin
               state_d = ARB_STREAM;
               gnt_d   = winner;
               len_d   = win_len;
               beat_d  = '0;
            end
         end
         ARB_STREAM: begin
            // Abort wins over a coincident handshake; both end the burst the same way.
            if (abort || (hs && last_beat)) begin
               state_d  = ARB_IDLE;
               gnt_d    = '0;
               done_d   = 1'b1;
               rr_ptr_d = next_ptr;
            end else if (hs) begin
               beat_d = beat_q + LEN_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      gen_rst_o_w = (state_q == ARB_IDLE);
      valid_o_w   = (state_q == ARB_STREAM);
      gen_en_o_w  = (state_q == ARB_STREAM) && ready_i_w;
      last_o_w    = (state_q == ARB_STREAM) && last_beat && !abort;
      gnt_o_w     = gnt_q;
      done_o_w    = done_q;
      data_o_w    = gen_seq_i_w;
   end

endmodule

// File: doc/seq_gen_arbiter.md
# seq_gen_arbiter

Shares one `seq_generator` instance between `NUM_REQ` requesters, granting bursts of sequence values round-robin. Each granted requester receives its burst starting from the generator's reset value. The block owns the generator's reset and advance-enable. It presents generator output to the consumer over a valid/ready handshake with a last-beat marker. It sits between the requester ports and the single `seq_generator` datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `DATA_W`, default 32: generator output width.
- `LEN_W`, default 8: burst-length field width.
- `clk_w` in 1: clock, rising edge.
- `reset_n_w` in 1: asynchronous active-low reset.
- `req_i_w` in `NUM_REQ`: request per requester, level.
- `len_i_w` in `NUM_REQ*LEN_W`: burst length per requester, packed; requester k uses bits `[k*LEN_W +: LEN_W]`.
- `gnt_o_w` out `NUM_REQ`: one-hot grant, held for the whole burst.
- `gen_rst_o_w` out 1: active-high synchronous reset to the generator.
- `gen_en_o_w` out 1: generator advance enable.
- `gen_seq_i_w` in `DATA_W`: generator output.
- `data_o_w` out `DATA_W`: equals `gen_seq_i_w`, pass-through.
- `valid_o_w` out 1: data valid.
- `ready_i_w` in 1: consumer ready.
- `last_o_w` out 1: final beat of the burst.
- `done_o_w` out 1: one-cycle pulse after the burst completes.

## Operation
- FSM states are IDLE and STREAM.
- IDLE:
  - `gen_rst_o_w`=1, `valid_o_w`=0, `gnt_o_w`=0.
  - Eligible requester: `req_i_w[k]`=1 and its `len` is non-zero. A request with `len`=0 is never granted.
  - Winner: first eligible index at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On a winner: latch the grant and its `len`, set beat count to 0, go to STREAM.
- STREAM:
  - `gen_rst_o_w`=0, `valid_o_w`=1, `gen_en_o_w`=`ready_i_w`.
  - Handshake: `valid_o_w` and `ready_i_w` both 1. Each handshake increments the beat count.
  - `last_o_w`=1 when beat count equals latched `len` minus 1.
  - Handshake on the last beat: go to IDLE, pulse `done_o_w` next cycle, set `rr_ptr` to granted index + 1 mod `NUM_REQ`.
- `req_i_w` and `len_i_w` are sampled only in IDLE. Dropping a request or changing `len` mid-burst has no effect.
- With `ready_i_w` low, `gen_en_o_w`=0. The generator holds, so `data_o_w` stays stable.
- Beat counter is `LEN_W` bits wide. A maximum burst of 2^LEN_W−1 beats never wraps.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `gnt_o_w`=0, `valid_o_w`=0, `last_o_w`=0, `done_o_w`=0, `gen_en_o_w`=0, `gen_rst_o_w`=1.
- Request to first valid: 1 cycle.
  - Request sampled at edge N; `valid_o_w`=1 from N.
  - The generator leaves reset in that same cycle and shows its reset value.
- Throughput: one beat per cycle while `ready_i_w`=1.
- IDLE gap: after each burst the block spends at least 1 cycle in IDLE. This cycle re-resets the generator.
- `done_o_w` is asserted in that IDLE cycle.
- Reset asserted mid-burst: outputs take reset values immediately and asynchronously. The burst is lost.

## Configuration
- `SEQ_GEN_ARB_ABORT_EN` defined: adds input `abort_i_w`, width 1.
  - `abort_i_w`=1 in STREAM: go to IDLE next edge; no further beats; `last_o_w` is not asserted.
  - `done_o_w` still pulses.
  - `rr_ptr` advances as for a normal completion.
  - `abort_i_w` is ignored in IDLE.
- Undefined: port absent; bursts always run to completion.

## Structure
- Package `seq_gen_arb_pkg` holds:
  - the state enum `arb_state_t`;
  - the default parameter constants.
- Sub-module `rr_picker`:
  - combinational round-robin selector;
  - inputs: eligible vector, pointer;
  - outputs: one-hot winner, `any` flag.
- FSM, beat counter and pointer live in the top module.

## Test plan
- Single request: req0=1, len0=5, `ready_i_w` tied 1.
  - Exactly 5 beats, matching the first 5 generator values after reset.
  - `last_o_w` on beat 5; `done_o_w` one cycle later.
- All four request, len=3, requests held: grant order 0,1,2,3,0.
  - Each burst restarts at the generator reset value.
- Backpressure: len=4, `ready_i_w` toggling 1,0,0,1,….
  - `data_o_w` stable while not ready.
  - Exactly 4 handshakes, no value skipped or repeated.
- Zero-length request: req1 with len=0 alongside req2 with len=2.
  - Only requester 2 is granted; `gnt_o_w[1]` never 1.
- Mid-burst reset: `reset_n_w` low at beat 3 of 10.
  - Outputs at reset values the same cycle.
  - After release with req held, a new burst starts from the reset value with grant from `rr_ptr`=0.
- Abort, built with `SEQ_GEN_ARB_ABORT_EN`: abort at beat 2 of 6.
  - `valid_o_w`=0 next cycle, `done_o_w` pulses, `last_o_w` never asserted.
  - Next grant goes to the next requester.
